mdu_iter_div: RTL and testbench

- Parametrised iterative radix-2 restoring divider for the EX stage. It is the next-generation DIV/DIVU engine that feeds HILO through the WB lo/hi path.
- Handles signed and unsigned operands, any WIDTH, optional early-out on dividend leading zeros, cancellation and divide-by-zero flagging.
- Raises a stall request toward CTRL while computing, and delivers quotient/remainder with a one-cycle ready pulse.

---
 rtl/mdu_iter_div.sv | 154 +++++++++++++++
 tb/tb_mdu_iter_div.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mdu_iter_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU, signed via magnitude plus sign fix-up.
// Holds the pipeline through stallreq and pulses ready for one cycle when results are valid.
module mdu_iter_div #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stallreq,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, CALC, ZERO, FIX, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_p;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] dvs_mag;
    logic             q_neg;
    logic             r_neg;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic [CW-1:0]    lz;
    logic [CW-1:0]    k;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;

    function automatic logic [CW-1:0] lead_zeros(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + CW'(1);
            end
        end
        return n;
    endfunction

    // Operand magnitudes and the iteration count chosen at launch
    always_comb begin
        dvd_neg = signed_op & dividend[WIDTH-1];
        dvs_neg = signed_op & divisor[WIDTH-1];
        abs_dvd = dvd_neg ? -dividend : dividend;
        abs_dvs = dvs_neg ? -divisor : divisor;
        lz      = EARLY_OUT ? lead_zeros(abs_dvd) : '0;
        k       = CW'(WIDTH) - lz;
        partial = {rem_p, dvd_sh[WIDTH-1]};
        trial   = partial - {1'b0, dvs_mag};
    end

    always_comb begin
        state_next = state;
        if (annul) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) state_next = ZERO;
                        else if (k == '0)  state_next = FIX;
                        else               state_next = CALC;
                    end
                end
                CALC:    if (count == CW'(1)) state_next = FIX;
                ZERO:    state_next = DONE;
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq = ((state == IDLE) & start & ~annul) | (state == CALC)
                 | (state == ZERO) | (state == FIX);
        ready    = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Datapath; an annulled cycle never touches the result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            rem_p       <= '0;
            dvd_sh      <= '0;
            quo_acc     <= '0;
            dvs_mag     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (!annul) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        rem_p       <= '0;
                        quo_acc     <= '0;
                        dvs_mag     <= abs_dvs;
                        q_neg       <= dvd_neg ^ dvs_neg;
                        r_neg       <= dvd_neg;
                        if (divisor == '0) begin
                            dvd_sh <= dividend;
                            count  <= '0;
                        end else begin
                            dvd_sh <= abs_dvd << lz;
                            count  <= k;
                        end
                    end
                end
                CALC: begin
                    dvd_sh  <= dvd_sh << 1;
                    quo_acc <= {quo_acc[WIDTH-2:0], ~trial[WIDTH]};
                    rem_p   <= trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
                    count   <= count - CW'(1);
                end
                ZERO: begin
                    quotient    <= '1;
                    remainder   <= dvd_sh;
                    div_by_zero <= 1'b1;
                end
                FIX: begin
                    quotient  <= q_neg ? -quo_acc : quo_acc;
                    remainder <= r_neg ? -rem_p : rem_p;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter_div.sv
// Directed bench for mdu_iter_div: one instance without and one with early-out,
// sharing operands and reset but launched through separate start lines.
module tb_mdu_iter_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic        signed_op, annul;
    logic [31:0] dividend, divisor;
    logic        stallreq0, ready0, div_by_zero0;
    logic        stallreq1, ready1, div_by_zero1;
    logic [31:0] quotient0, remainder0, quotient1, remainder1;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    mdu_iter_div #(.WIDTH(32), .EARLY_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .signed_op(signed_op), .annul(annul),
        .dividend(dividend), .divisor(divisor), .stallreq(stallreq0), .ready(ready0),
        .quotient(quotient0), .remainder(remainder0), .div_by_zero(div_by_zero0)
    );

    mdu_iter_div #(.WIDTH(32), .EARLY_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .signed_op(signed_op), .annul(annul),
        .dividend(dividend), .divisor(divisor), .stallreq(stallreq1), .ready(ready1),
        .quotient(quotient1), .remainder(remainder1), .div_by_zero(div_by_zero1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one operation; returns at the falling edge of the ready cycle
    task automatic applyStimulus(input string tag, input bit eo, input bit sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input int exp_cycle, input logic [31:0] exp_q,
                                 input logic [31:0] exp_r, input logic exp_dbz);
        int   ready_cycle;
        int   stall_bad;
        logic rdy, stl;
        ready_cycle = -1;
        stall_bad   = 0;
        stl         = 1'b1;
        @(posedge clk); #1;
        signed_op = sgn;
        dividend  = a;
        divisor   = b;
        annul     = 1'b0;
        if (eo) start1 = 1'b1;
        else    start0 = 1'b1;
        @(negedge clk);
        checkOutput({tag, " stall c0"}, eo ? stallreq1 : stallreq0, 32'd1);
        checkOutput({tag, " ready c0"}, eo ? ready1 : ready0, 32'd0);
        @(posedge clk); #1;
        start0   = 1'b0;
        start1   = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0;
        for (int c = 1; c <= 60 && ready_cycle < 0; c++) begin
            @(negedge clk);
            rdy = eo ? ready1 : ready0;
            stl = eo ? stallreq1 : stallreq0;
            if (rdy) ready_cycle = c;
            else if (!stl) stall_bad++;
        end
        checkOutput({tag, " ready cycle"}, ready_cycle, exp_cycle);
        checkOutput({tag, " stall gaps"}, stall_bad, 32'd0);
        checkOutput({tag, " stall at ready"}, stl, 32'd0);
        checkOutput({tag, " quotient"}, eo ? quotient1 : quotient0, exp_q);
        checkOutput({tag, " remainder"}, eo ? remainder1 : remainder0, exp_r);
        checkOutput({tag, " div_by_zero"}, eo ? div_by_zero1 : div_by_zero0, exp_dbz);
    endtask

    initial begin
        int spurious;
        rst       = 1'b0;
        start0    = 1'b0;
        start1    = 1'b0;
        signed_op = 1'b0;
        annul     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset quotient", quotient0, 32'd0);
        checkOutput("reset remainder", remainder0, 32'd0);
        checkOutput("reset dbz", div_by_zero0, 32'd0);
        checkOutput("reset ready", ready0, 32'd0);
        checkOutput("reset stallreq", stallreq0, 32'd0);
        checkOutput("reset ready eo", ready1, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        $display("[TB] plain divider");
        applyStimulus("divu 100/7", 1'b0, 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);
        applyStimulus("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        applyStimulus("div 7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 32'd1, 1'b0);
        applyStimulus("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, 1'b0);
        applyStimulus("divu 5/0", 1'b0, 1'b0, 32'd5, 32'd0, 2, 32'hFFFF_FFFF, 32'd5, 1'b1);
        applyStimulus("divu 9/3", 1'b0, 1'b0, 32'd9, 32'd3, 34, 32'd3, 32'd0, 1'b0);

        $display("[TB] annul mid-operation");
        spurious = 0;
        @(posedge clk); #1;
        signed_op = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        start0    = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            if (c == 10) annul = 1'b1;
            @(negedge clk);
            if (ready0) spurious++;
        end
        checkOutput("annul no ready", spurious, 32'd0);
        checkOutput("annul quotient held", quotient0, 32'd3);
        checkOutput("annul remainder held", remainder0, 32'd0);
        applyStimulus("after annul 1000/3", 1'b0, 1'b0, 32'd1000, 32'd3, 34, 32'd333, 32'd1, 1'b0);

        $display("[TB] reset mid-operation");
        spurious = 0;
        @(posedge clk); #1;
        dividend = 32'd200;
        divisor  = 32'd7;
        start0   = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            if (c == 5) rst = 1'b0;
        end
        @(negedge clk);
        checkOutput("midreset quotient", quotient0, 32'd0);
        checkOutput("midreset remainder", remainder0, 32'd0);
        checkOutput("midreset ready", ready0, 32'd0);
        checkOutput("midreset stallreq", stallreq0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready0) spurious++;
        end
        checkOutput("midreset no ready", spurious, 32'd0);
        checkOutput("midreset idle", stallreq0, 32'd0);

        $display("[TB] early-out divider");
        applyStimulus("eo divu 3/1", 1'b1, 1'b0, 32'd3, 32'd1, 4, 32'd3, 32'd0, 1'b0);
        applyStimulus("eo divu 0/9", 1'b1, 1'b0, 32'd0, 32'd9, 2, 32'd0, 32'd0, 1'b0);
        applyStimulus("eo divu max/1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 34, 32'hFFFF_FFFF, 32'd0, 1'b0);
        applyStimulus("eo div -100/7", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 9, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
